game_stage_sequencer: RTL
=========================

Name: game_stage_sequencer

Overview:
- Parametrised successor to the game's single-direction stage counter.
- Tracks the current stage and supports next, previous, jump and restart commands.
- Records the highest unlocked stage, optionally locks jumps to unlocked stages, and selects wrap or saturate at the last stage.
- Sits between the menu/game-logic FSM and the map loader; each stage change is passed to the loader over a req/ack handshake.

Parameters:
- N, 2, number of stages (N >= 2).
- CounterBits, 2, width of stage/index buses; must satisfy 2^CounterBits >= N.
- WRAP, 1: 1 means next on stage N-1 returns to 0; 0 means it saturates at N-1.
- LOCK, 1: 1 means jump is only allowed to stages <= max_unlocked; 0 means any stage < N.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- next  in  1  advance command (stage cleared).
- prev  in  1  step-back command.
- jump  in  1  jump command.
- jump_idx  in  CounterBits  jump target.
- restart  in  1  reload current stage.
- load_ack  in  1  map loader has finished loading the requested stage.
- stage  out  CounterBits  current stage, registered.
- max_unlocked  out  CounterBits  highest stage unlocked, registered.
- load_req  out  1  map-load request, level, registered.
- busy  out  1  high while in LOAD state; equals load_req.
- done  out  1  one-cycle pulse when next is accepted on stage N-1.
- err  out  1  one-cycle pulse when a jump is rejected.

Behaviour:
- Reset (async, rst=1): stage=0, max_unlocked=0, state=LOAD, load_req=1, busy=1, done=0, err=0. Stage 0 is therefore loaded after every reset. Reset during LOAD abandons the pending request and restarts it for stage 0.
- FSM has two states: IDLE and LOAD.
- LOAD state:
  - load_req=1, held stable.
  - All commands are ignored, with no err/done pulses.
  - load_ack=1 at a clock edge moves to IDLE; load_req drops on that edge (one-cycle ack is sufficient).
- IDLE state:
  - load_ack is ignored.
  - One command is accepted per cycle. Priority: restart > jump > next > prev. Lower-priority commands in the same cycle are dropped.
- restart: stage unchanged; go to LOAD.
- jump:
  - Rejected if jump_idx >= N, or if LOCK=1 and jump_idx > max_unlocked. Rejection gives err=1 for one cycle, stays in IDLE, changes nothing else.
  - Otherwise stage=jump_idx and go to LOAD. Jumping to the current stage is legal and reloads it.
- next on stage s < N-1: stage=s+1; max_unlocked=max(max_unlocked, s+1); go to LOAD.
- next on stage N-1:
  - done=1 for one cycle.
  - WRAP=1: stage=0, go to LOAD.
  - WRAP=0: stage stays N-1, stays in IDLE (no reload).
  - max_unlocked stays at N-1.
- prev: stage s > 0 gives stage=s-1 and go to LOAD. At s=0 there is no effect (prev never wraps).
- max_unlocked is monotonic, never exceeds N-1, and is cleared only by rst.
- Timing:
  - All outputs are registered.
  - Command sampled at edge k: stage/load_req updated at edge k.
  - Earliest next command accepted: the edge after load_ack is sampled.
- Widths: all comparisons are unsigned at CounterBits. Index values N..2^CounterBits-1 are never produced on stage.

Test Plan (N=4, CounterBits=2, WRAP=1, LOCK=1 unless noted):
- Reset then ack: release rst -> stage=0, load_req=1. load_ack for 1 cycle -> load_req=0, busy=0 next edge. Assert rst mid-LOAD after stage=2 -> stage=0, load_req=1 immediately (async).
- Progress and unlock: next+ack three times -> stage 1,2,3 and max_unlocked 1,2,3. Fourth next -> done pulse 1 cycle, stage=0, load_req=1, max_unlocked stays 3.
- Lock check:
  - After reset, max_unlocked=0; jump jump_idx=2 -> err pulse, stage=0, no load_req.
  - After one next, jump 1 -> accepted.
  - With LOCK=0, jump 3 -> accepted; jump_idx=3 with N=3 -> err.
- Busy masking: in LOAD, pulse next, prev, jump and restart -> stage unchanged, no err/done. Ack and next in the same cycle -> next dropped.
- Priority and boundaries:
  - restart+jump+next together at stage 2 -> stage 2 reloaded.
  - prev at stage 0 -> nothing.
  - WRAP=0: next at stage 3 -> done pulse, stage=3, load_req stays 0.

Source files
------------

// File: rtl/game_stage_sequencer.sv
// Stage sequencer between the menu/game-logic FSM and the map loader.
// Tracks current and highest-unlocked stage; every stage change is handed off via load_req/load_ack.
module game_stage_sequencer #(
  parameter int unsigned N           = 2,
  parameter int unsigned CounterBits = 2,
  parameter int unsigned WRAP        = 1,
  parameter int unsigned LOCK        = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   next,
  input  logic                   prev,
  input  logic                   jump,
  input  logic [CounterBits-1:0] jump_idx,
  input  logic                   restart,
  input  logic                   load_ack,
  output logic [CounterBits-1:0] stage,
  output logic [CounterBits-1:0] max_unlocked,
  output logic                   load_req,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  localparam logic [CounterBits-1:0] LAST = CounterBits'(N - 1);

  state_t                 state;
  logic [CounterBits-1:0] stage_inc;
  logic [CounterBits-1:0] stage_dec;
  logic                   jump_ok;

  always_comb begin
    stage_inc = stage + 1'b1;
    stage_dec = stage - 1'b1;
    // N <= 2^CounterBits, so "<= N-1" is the unsigned in-range test
    jump_ok   = (jump_idx <= LAST) && ((LOCK == 0) || (jump_idx <= max_unlocked));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      stage        <= '0;
      max_unlocked <= '0;
      load_req     <= 1'b1;
      busy         <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        LOAD: begin
          if (load_ack) begin
            state    <= IDLE;
            load_req <= 1'b0;
            busy     <= 1'b0;
          end
        end
        IDLE: begin
          if (restart) begin
            state    <= LOAD;
            load_req <= 1'b1;
            busy     <= 1'b1;
          end else if (jump) begin
            if (jump_ok) begin
              stage    <= jump_idx;
              state    <= LOAD;
              load_req <= 1'b1;
              busy     <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else if (next) begin
            if (stage == LAST) begin
              done <= 1'b1;
              if (WRAP != 0) begin
                stage    <= '0;
                state    <= LOAD;
                load_req <= 1'b1;
                busy     <= 1'b1;
              end
            end else begin
              stage <= stage_inc;
              if (stage_inc > max_unlocked) begin
                max_unlocked <= stage_inc;
              end
              state    <= LOAD;
              load_req <= 1'b1;
              busy     <= 1'b1;
            end
          end else if (prev && (stage != '0)) begin
            stage    <= stage_dec;
            state    <= LOAD;
            load_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
